// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX pipeline register: ALU control codes, opcode/funct
// constants, control word layout and the bubble control word.
package id_ex_stage_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SLL = 3'd4,
      ALU_SRL = 3'd5,
      ALU_SLT = 3'd6
   } alu_ctrl_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_SLTI  = 6'h0A;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // EXT_NONE means the second operand is rt_data rather than the immediate.
   typedef enum logic [1:0] {
      EXT_NONE = 2'd0,
      EXT_SIGN = 2'd1,
      EXT_ZERO = 2'd2
   } ext_e;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic branch;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   typedef struct packed {
      alu_ctrl_e alu;
      ctrl_t     ctrl;
      ext_e      ext;
      logic      is_rtype;
      logic      uses_rt;
      logic      illegal;
   } dec_t;

   function automatic logic [31:0] extend_imm(input logic [15:0] imm, input ext_e ext);
      return (ext == EXT_SIGN) ? {{16{imm[15]}}, imm} : {16'h0000, imm};
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decoded-instruction bus into the ID/EX register and the EX-side outputs back out.
// master = instruction source / EX consumer, slave = id_ex_stage.
interface id_ex_stage_if;
   logic        in_valid;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  shamt_in;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [4:0]  rd_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [15:0] imm;
   logic        stall;
   logic        flush;

   logic        ex_valid;
   logic [31:0] reg1;
   logic [31:0] reg2;
   logic [2:0]  ALUcontrol;
   logic [4:0]  shamt;
   logic [4:0]  dest_addr;
   logic        reg_write;
   logic        mem_read;
   logic        mem_write;
   logic        mem_to_reg;
   logic        branch;
   logic [31:0] store_data;
   logic        hazard_stall;
   logic [7:0]  illegal_cnt;

   modport master (
      output in_valid, opcode, funct, shamt_in, rs_addr, rt_addr, rd_addr,
             rs_data, rt_data, imm, stall, flush,
      input  ex_valid, reg1, reg2, ALUcontrol, shamt, dest_addr, reg_write,
             mem_read, mem_write, mem_to_reg, branch, store_data,
             hazard_stall, illegal_cnt
   );

   modport slave (
      input  in_valid, opcode, funct, shamt_in, rs_addr, rt_addr, rd_addr,
             rs_data, rt_data, imm, stall, flush,
      output ex_valid, reg1, reg2, ALUcontrol, shamt, dest_addr, reg_write,
             mem_read, mem_write, mem_to_reg, branch, store_data,
             hazard_stall, illegal_cnt
   );
endinterface

// File: rtl/alu_decode.sv
// Combinational instruction decode: opcode/funct -> ALU control, control bits,
// immediate extension type, operand usage and illegal flag.
module alu_decode
   import id_ex_stage_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output dec_t       dec
);

   always_comb begin
      dec          = '0;
      dec.alu      = ALU_ADD;
      dec.ctrl     = CTRL_BUBBLE;
      dec.ext      = EXT_NONE;
      unique case (opcode)
         OP_RTYPE: begin
            dec.is_rtype       = 1'b1;
            dec.uses_rt        = 1'b1;
            dec.ctrl.reg_write = 1'b1;
            unique case (funct)
               FN_ADD:  dec.alu = ALU_ADD;
               FN_SUB:  dec.alu = ALU_SUB;
               FN_AND:  dec.alu = ALU_AND;
               FN_OR:   dec.alu = ALU_OR;
               FN_SLL:  dec.alu = ALU_SLL;
               FN_SRL:  dec.alu = ALU_SRL;
               FN_SLT:  dec.alu = ALU_SLT;
               default: begin
                  dec.illegal = 1'b1;
                  dec.ctrl    = CTRL_BUBBLE;
               end
            endcase
         end
         OP_ADDI: begin
            dec.ext            = EXT_SIGN;
            dec.ctrl.reg_write = 1'b1;
         end
         OP_LW: begin
            dec.ext             = EXT_SIGN;
            dec.ctrl.reg_write  = 1'b1;
            dec.ctrl.mem_read   = 1'b1;
            dec.ctrl.mem_to_reg = 1'b1;
         end
         OP_SW: begin
            dec.ext            = EXT_SIGN;
            dec.uses_rt        = 1'b1;
            dec.ctrl.mem_write = 1'b1;
         end
         OP_BEQ: begin
            // beq compares two registers; its immediate is the branch offset.
            dec.alu         = ALU_SUB;
            dec.uses_rt     = 1'b1;
            dec.ctrl.branch = 1'b1;
         end
         OP_ANDI: begin
            dec.alu            = ALU_AND;
            dec.ext            = EXT_ZERO;
            dec.ctrl.reg_write = 1'b1;
         end
         OP_ORI: begin
            dec.alu            = ALU_OR;
            dec.ext            = EXT_ZERO;
            dec.ctrl.reg_write = 1'b1;
         end
         OP_SLTI: begin
            dec.alu            = ALU_SLT;
            dec.ext            = EXT_SIGN;
            dec.ctrl.reg_write = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush/stall priority, saturating illegal-instruction
// counter and optional load-use hazard detection (enabled by ID_EX_HAZARD_DETECT_EN).
module id_ex_stage
   import id_ex_stage_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   id_ex_stage_if.slave  bus
);

   dec_t dec;

   alu_decode u_alu_decode (
      .opcode (bus.opcode),
      .funct  (bus.funct),
      .dec    (dec)
   );

   logic        ex_valid_q,    ex_valid_d;
   logic [31:0] reg1_q,        reg1_d;
   logic [31:0] reg2_q,        reg2_d;
   logic [2:0]  alu_q,         alu_d;
   logic [4:0]  shamt_q,       shamt_d;
   logic [4:0]  dest_q,        dest_d;
   ctrl_t       ctrl_q,        ctrl_d;
   logic [31:0] store_q,       store_d;
   logic [7:0]  illegal_cnt_q, illegal_cnt_d;
   logic        hazard;

`ifdef ID_EX_HAZARD_DETECT_EN
   // A load in EX whose destination is read by the incoming instruction.
   assign hazard = ex_valid_q && ctrl_q.mem_read && (dest_q != 5'd0) && bus.in_valid &&
                   ((dest_q == bus.rs_addr) || ((dest_q == bus.rt_addr) && dec.uses_rt));
`else
   logic unused_hazard_inputs;
   assign unused_hazard_inputs = ^{bus.rs_addr, bus.rt_addr, dec.uses_rt};
   assign hazard = 1'b0;
`endif

   always_comb begin
      ex_valid_d    = ex_valid_q;
      reg1_d        = reg1_q;
      reg2_d        = reg2_q;
      alu_d         = alu_q;
      shamt_d       = shamt_q;
      dest_d        = dest_q;
      ctrl_d        = ctrl_q;
      store_d       = store_q;
      illegal_cnt_d = illegal_cnt_q;

      if (!bus.flush && bus.stall) begin
         // hold everything
      end else if (bus.flush || hazard || !bus.in_valid || dec.illegal) begin
         ex_valid_d = 1'b0;
         reg1_d     = '0;
         reg2_d     = '0;
         alu_d      = ALU_ADD;
         shamt_d    = '0;
         dest_d     = '0;
         ctrl_d     = CTRL_BUBBLE;
         store_d    = '0;
         // Only a genuinely issued illegal instruction counts; squashed or held ones do not.
         if (!bus.flush && !hazard && bus.in_valid && dec.illegal && illegal_cnt_q != 8'hFF)
            illegal_cnt_d = illegal_cnt_q + 8'd1;
      end else begin
         ex_valid_d = 1'b1;
         reg1_d     = bus.rs_data;
         reg2_d     = (dec.ext == EXT_NONE) ? bus.rt_data : extend_imm(bus.imm, dec.ext);
         alu_d      = dec.alu;
         shamt_d    = dec.is_rtype ? bus.shamt_in : 5'd0;
         dest_d     = dec.is_rtype ? bus.rd_addr : bus.rt_addr;
         ctrl_d     = dec.ctrl;
         store_d    = bus.rt_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid_q    <= 1'b0;
         reg1_q        <= '0;
         reg2_q        <= '0;
         alu_q         <= ALU_ADD;
         shamt_q       <= '0;
         dest_q        <= '0;
         ctrl_q        <= CTRL_BUBBLE;
         store_q       <= '0;
         illegal_cnt_q <= '0;
      end else begin
         ex_valid_q    <= ex_valid_d;
         reg1_q        <= reg1_d;
         reg2_q        <= reg2_d;
         alu_q         <= alu_d;
         shamt_q       <= shamt_d;
         dest_q        <= dest_d;
         ctrl_q        <= ctrl_d;
         store_q       <= store_d;
         illegal_cnt_q <= illegal_cnt_d;
      end
   end

   assign bus.ex_valid     = ex_valid_q;
   assign bus.reg1         = reg1_q;
   assign bus.reg2         = reg2_q;
   assign bus.ALUcontrol   = alu_q;
   assign bus.shamt        = shamt_q;
   assign bus.dest_addr    = dest_q;
   assign bus.reg_write    = ctrl_q.reg_write;
   assign bus.mem_read     = ctrl_q.mem_read;
   assign bus.mem_write    = ctrl_q.mem_write;
   assign bus.mem_to_reg   = ctrl_q.mem_to_reg;
   assign bus.branch       = ctrl_q.branch;
   assign bus.store_data   = store_q;
   assign bus.hazard_stall = hazard;
   assign bus.illegal_cnt  = illegal_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector table plus hand-written hazard, stall/flush, saturation and
// reset sequences for id_ex_stage.
module tb_id_ex_stage;
   import id_ex_stage_pkg::*;

`ifdef ID_EX_HAZARD_DETECT_EN
   localparam logic HZ = 1'b1;
`else
   localparam logic HZ = 1'b0;
`endif

   typedef struct packed {
      logic        valid;
      logic [5:0]  opcode;
      logic [5:0]  funct;
      logic [4:0]  shamt;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] rsd;
      logic [31:0] rtd;
      logic [15:0] imm;
   } in_t;

   typedef struct packed {
      logic        ev;
      logic [31:0] reg1;
      logic [31:0] reg2;
      logic [2:0]  alu;
      logic [4:0]  shamt;
      logic [4:0]  dest;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        m2r;
      logic        br;
      logic [31:0] store;
   } exp_t;

   typedef struct {
      in_t  in;
      exp_t ex;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   id_ex_stage_if bus();

   id_ex_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input in_t v);
      bus.in_valid = v.valid;
      bus.opcode   = v.opcode;
      bus.funct    = v.funct;
      bus.shamt_in = v.shamt;
      bus.rs_addr  = v.rs;
      bus.rt_addr  = v.rt;
      bus.rd_addr  = v.rd;
      bus.rs_data  = v.rsd;
      bus.rt_data  = v.rtd;
      bus.imm      = v.imm;
   endtask

   task automatic check_out(input string tag, input exp_t e);
      chk({tag, ".ex_valid"},   {31'd0, bus.ex_valid},   {31'd0, e.ev});
      chk({tag, ".reg1"},       bus.reg1,                e.reg1);
      chk({tag, ".reg2"},       bus.reg2,                e.reg2);
      chk({tag, ".ALUcontrol"}, {29'd0, bus.ALUcontrol}, {29'd0, e.alu});
      chk({tag, ".shamt"},      {27'd0, bus.shamt},      {27'd0, e.shamt});
      chk({tag, ".dest_addr"},  {27'd0, bus.dest_addr},  {27'd0, e.dest});
      chk({tag, ".ctrl"},
          {27'd0, bus.reg_write, bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.branch},
          {27'd0, e.rw, e.mr, e.mw, e.m2r, e.br});
      chk({tag, ".store_data"}, bus.store_data,          e.store);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic in_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rsd,
                              input logic [31:0] rtd, input logic [15:0] imm);
      return '{1'b1, op, fn, 5'd0, rs, rt, rd, rsd, rtd, imm};
   endfunction

   vec_t vecs [18];
   exp_t bubble;
   exp_t e_sub;
   exp_t e_add;

   initial begin
      bubble = '0;
      vecs[0]  = '{mk(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0),
                   '{1'b1, 32'd5, 32'd7, 3'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd7}};
      vecs[1]  = '{'{1'b1, 6'h00, 6'h22, 5'd4, 5'd10, 5'd11, 5'd12, 32'd100, 32'd30, 16'h0},
                   '{1'b1, 32'd100, 32'd30, 3'd1, 5'd4, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd30}};
      vecs[2]  = '{mk(6'h00, 6'h24, 5'd1, 5'd2, 5'd3, 32'hF0F0, 32'hFF00, 16'h0),
                   '{1'b1, 32'hF0F0, 32'hFF00, 3'd2, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFF00}};
      vecs[3]  = '{mk(6'h00, 6'h25, 5'd1, 5'd2, 5'd3, 32'hF0F0, 32'hFF00, 16'h0),
                   '{1'b1, 32'hF0F0, 32'hFF00, 3'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFF00}};
      vecs[4]  = '{'{1'b1, 6'h00, 6'h00, 5'd7, 5'd1, 5'd2, 5'd4, 32'd0, 32'd3, 16'h0},
                   '{1'b1, 32'd0, 32'd3, 3'd4, 5'd7, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3}};
      vecs[5]  = '{'{1'b1, 6'h00, 6'h02, 5'd31, 5'd1, 5'd2, 5'd31, 32'd0, 32'h8000_0000, 16'h0},
                   '{1'b1, 32'd0, 32'h8000_0000, 3'd5, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0000}};
      vecs[6]  = '{mk(6'h00, 6'h2A, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFF, 32'd1, 16'h0),
                   '{1'b1, 32'hFFFF_FFFF, 32'd1, 3'd6, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1}};
      vecs[7]  = '{'{1'b1, 6'h08, 6'h3F, 5'd9, 5'd1, 5'd5, 5'd8, 32'd1, 32'd99, 16'hFFFF},
                   '{1'b1, 32'd1, 32'hFFFF_FFFF, 3'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd99}};
      vecs[8]  = '{mk(6'h0D, 6'h00, 5'd1, 5'd6, 5'd0, 32'd2, 32'd3, 16'hFFFF),
                   '{1'b1, 32'd2, 32'h0000_FFFF, 3'd3, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3}};
      vecs[9]  = '{mk(6'h0C, 6'h00, 5'd1, 5'd7, 5'd0, 32'd2, 32'd3, 16'h8001),
                   '{1'b1, 32'd2, 32'h0000_8001, 3'd2, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3}};
      vecs[10] = '{mk(6'h0A, 6'h00, 5'd1, 5'd8, 5'd0, 32'd5, 32'd3, 16'h8000),
                   '{1'b1, 32'd5, 32'hFFFF_8000, 3'd6, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3}};
      vecs[11] = '{mk(6'h23, 6'h00, 5'd1, 5'd9, 5'd0, 32'd1000, 32'd55, 16'h0004),
                   '{1'b1, 32'd1000, 32'd4, 3'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd55}};
      vecs[12] = '{mk(6'h2B, 6'h00, 5'd2, 5'd6, 5'd0, 32'd2000, 32'hDEAD_BEEF, 16'hFFFC),
                   '{1'b1, 32'd2000, 32'hFFFF_FFFC, 3'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF}};
      vecs[13] = '{mk(6'h04, 6'h00, 5'd3, 5'd4, 5'd0, 32'd8, 32'd8, 16'h0010),
                   '{1'b1, 32'd8, 32'd8, 3'd1, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd8}};
      vecs[14] = '{'{1'b0, 6'h00, 6'h20, 5'd0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0}, bubble};
      vecs[15] = '{mk(6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h1234), bubble};
      vecs[16] = '{mk(6'h00, 6'h21, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0), bubble};
      vecs[17] = '{mk(6'h09, 6'h00, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0001), bubble};

      e_sub = vecs[1].ex;
      e_add = vecs[0].ex;

      // Reset state
      reset     = 1'b1;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      drive(vecs[14].in);
      #12;
      check_out("reset", bubble);
      chk("reset.illegal_cnt", {24'd0, bus.illegal_cnt}, 32'd0);
      chk("reset.hazard_stall", {31'd0, bus.hazard_stall}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].in);
         tick();
         $display("vec %0d op=%02h fn=%02h -> ex_valid=%0b alu=%0d reg2=%08h dest=%0d",
                  i, vecs[i].in.opcode, vecs[i].in.funct, bus.ex_valid, bus.ALUcontrol,
                  bus.reg2, bus.dest_addr);
         check_out($sformatf("vec%0d", i), vecs[i].ex);
      end
      chk("table.illegal_cnt", {24'd0, bus.illegal_cnt}, 32'd3);

      // Load-use hazard on rs
      drive(mk(6'h23, 6'h00, 5'd1, 5'd4, 5'd0, 32'd0, 32'd0, 16'h0));
      tick();
      drive(mk(6'h00, 6'h20, 5'd4, 5'd2, 5'd7, 32'd11, 32'd22, 16'h0));
      #1;
      chk("hz.rs.hazard_stall", {31'd0, bus.hazard_stall}, {31'd0, HZ});
      tick();
      $display("hazard rs: ex_valid=%0b hazard_stall=%0b", bus.ex_valid, bus.hazard_stall);
      chk("hz.rs.ex_valid", {31'd0, bus.ex_valid}, {31'd0, ~HZ});
      chk("hz.rs.cleared", {31'd0, bus.hazard_stall}, 32'd0);
      tick();
      chk("hz.reissue.ex_valid", {31'd0, bus.ex_valid}, 32'd1);
      chk("hz.reissue.reg1", bus.reg1, 32'd11);
      chk("hz.reissue.reg2", bus.reg2, 32'd22);
      chk("hz.reissue.dest", {27'd0, bus.dest_addr}, 32'd7);

      // Hazard on rt only for instructions that read rt
      drive(mk(6'h23, 6'h00, 5'd1, 5'd4, 5'd0, 32'd0, 32'd0, 16'h0));
      tick();
      drive(mk(6'h00, 6'h22, 5'd2, 5'd4, 5'd7, 32'd0, 32'd0, 16'h0));
      #1;
      chk("hz.rt.rtype", {31'd0, bus.hazard_stall}, {31'd0, HZ});
      drive(mk(6'h08, 6'h00, 5'd1, 5'd4, 5'd0, 32'd0, 32'd0, 16'h0));
      #1;
      chk("hz.rt.addi", {31'd0, bus.hazard_stall}, 32'd0);
      drive(mk(6'h2B, 6'h00, 5'd1, 5'd4, 5'd0, 32'd0, 32'd0, 16'h0));
      #1;
      chk("hz.rt.sw", {31'd0, bus.hazard_stall}, {31'd0, HZ});
      drive('{1'b0, 6'h00, 6'h20, 5'd0, 5'd4, 5'd4, 5'd7, 32'd0, 32'd0, 16'h0});
      #1;
      chk("hz.invalid", {31'd0, bus.hazard_stall}, 32'd0);
      tick();
      drive(mk(6'h23, 6'h00, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 16'h0));
      tick();
      drive(mk(6'h00, 6'h20, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 16'h0));
      #1;
      chk("hz.dest0", {31'd0, bus.hazard_stall}, 32'd0);
      tick();

      // Stall freezes outputs for 3 cycles; illegal during stall not counted
      drive(vecs[1].in);
      tick();
      bus.stall = 1'b1;
      drive(vecs[15].in);
      for (int c = 0; c < 3; c++) begin
         tick();
         $display("stall cycle %0d: ex_valid=%0b reg1=%0d", c, bus.ex_valid, bus.reg1);
         check_out($sformatf("stall%0d", c), e_sub);
      end
      chk("stall.illegal_cnt", {24'd0, bus.illegal_cnt}, 32'd3);
      bus.flush = 1'b1;
      drive(vecs[0].in);
      tick();
      check_out("flush_stall", bubble);
      bus.stall = 1'b0;
      drive(vecs[15].in);
      tick();
      check_out("flush_illegal", bubble);
      chk("flush.illegal_cnt", {24'd0, bus.illegal_cnt}, 32'd3);
      bus.flush = 1'b0;

      // Saturation: 300 illegal opcodes
      drive(vecs[15].in);
      repeat (251) tick();
      chk("sat.254", {24'd0, bus.illegal_cnt}, 32'd254);
      tick();
      chk("sat.255", {24'd0, bus.illegal_cnt}, 32'd255);
      repeat (48) tick();
      $display("saturation: illegal_cnt=%0d", bus.illegal_cnt);
      chk("sat.hold", {24'd0, bus.illegal_cnt}, 32'd255);

      // Asynchronous reset mid-stall, then first edge loads normally
      drive(vecs[0].in);
      tick();
      check_out("pre_reset", e_add);
      bus.stall = 1'b1;
      drive(vecs[15].in);
      tick();
      @(negedge clk);
      reset = 1'b1;
      #1;
      $display("async reset: ex_valid=%0b illegal_cnt=%0d", bus.ex_valid, bus.illegal_cnt);
      check_out("async_reset", bubble);
      chk("async_reset.illegal_cnt", {24'd0, bus.illegal_cnt}, 32'd0);
      tick();
      check_out("reset_over_stall", bubble);
      @(negedge clk);
      reset     = 1'b0;
      bus.stall = 1'b0;
      drive(vecs[0].in);
      tick();
      check_out("post_reset", e_add);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  asynchronous active-high reset.
REQ-002 SHALL have inputs: in_valid 1 decoded instruction present; opcode 6; funct 6; shamt_in 5; rs_addr 5; rt_addr 5; rd_addr 5; rs_data 32; rt_data 32; imm 16.
REQ-003 SHALL have inputs: stall 1 downstream hold; flush 1 squash (branch taken).
REQ-004 SHALL have outputs: ex_valid 1; reg1 32; reg2 32; ALUcontrol 3; shamt 5; dest_addr 5; reg_write 1; mem_read 1; mem_write 1; mem_to_reg 1; branch 1; store_data 32.
REQ-005 SHALL have outputs: hazard_stall 1 (combinational load-use request to IF/ID); illegal_cnt 8 (saturating count of undecodable instructions).

Function
REQ-006 SHALL register all EX-side outputs on rising clk; latency exactly one cycle from inputs to outputs.
REQ-007 SHALL decode ALUcontrol: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 slt.
REQ-008 R-type (opcode 0x00) SHALL map funct 0x20->0, 0x22->1, 0x24->2, 0x25->3, 0x00->4, 0x02->5, 0x2A->6; reg1=rs_data, reg2=rt_data, dest_addr=rd_addr, reg_write=1.
REQ-009 I-type SHALL map opcode 0x08 addi->0, 0x23 lw->0, 0x2B sw->0, 0x04 beq->1, 0x0C andi->2, 0x0D ori->3, 0x0A slti->6; dest_addr=rt_addr.
REQ-010 imm SHALL be sign-extended for addi, lw, sw, beq, slti; zero-extended for andi, ori.
REQ-011 reg2 SHALL be extended imm for all I-type except beq (reg2=rt_data); store_data SHALL be rt_data.
REQ-012 Controls: lw mem_read=1, mem_to_reg=1, reg_write=1; sw mem_write=1, reg_write=0; beq branch=1, reg_write=0; addi/andi/ori/slti reg_write=1; shamt=shamt_in for R-type, 0 otherwise.
REQ-013 Unlisted opcode/funct with in_valid=1 SHALL load a bubble and increment illegal_cnt, saturating at 255.
REQ-014 Bubble = ex_valid=0, all control bits 0, dest_addr=0, ALUcontrol=0, data fields 0.
REQ-015 Priority per edge: flush > stall > hazard_stall > normal load.
REQ-016 flush=1 SHALL load a bubble regardless of stall; illegal_cnt unchanged.
REQ-017 stall=1 (flush=0) SHALL hold every registered output unchanged; illegal_cnt unchanged.
REQ-018 hazard_stall SHALL be 1 when ex_valid=1, mem_read=1, dest_addr!=0, in_valid=1, and dest_addr equals rs_addr, or equals rt_addr for R-type, sw or beq.
REQ-019 hazard_stall=1 (flush=0, stall=0) SHALL load a bubble; hazard_stall deasserts next cycle because the load has left.
REQ-020 in_valid=0 SHALL load a bubble.

Reset
REQ-021 reset SHALL asynchronously force bubble state on all registered outputs and illegal_cnt=0.
REQ-022 reset asserted mid-stall SHALL override stall; first post-reset edge SHALL load normally.

Configuration
REQ-023 Macro ID_EX_HAZARD_DETECT_EN defined: REQ-018/019 active.
REQ-024 Macro undefined: hazard_stall tied 0, no compare logic; load-use protection left to software.

Structure
REQ-025 Shared package SHALL hold ALUcontrol encodings, opcode and funct constants, and the bubble control-word constant.
REQ-026 Decode SHALL be a combinational sub-module alu_decode (opcode, funct -> ALUcontrol, control bits, ext-type, illegal); id_ex_stage holds registers, hazard logic, counter.

Verification
REQ-027 add: opcode 0, funct 0x20, rs_data 5, rt_data 7, rd_addr 3 -> next cycle ALUcontrol 0, reg1 5, reg2 7, dest_addr 3, reg_write 1.
REQ-028 addi imm 0xFFFF -> reg2 0xFFFFFFFF; ori imm 0xFFFF -> reg2 0x0000FFFF, ALUcontrol 3.
REQ-029 lw dest 4 loaded, then add rs_addr 4 -> hazard_stall 1, next cycle ex_valid 0; held add reissued -> loads normally (macro defined); macro undefined -> hazard_stall 0.
REQ-030 stall 1 for 3 cycles over sub -> outputs frozen; flush and stall together -> bubble.
REQ-031 opcode 0x3F 300 times -> illegal_cnt 255; reset mid-stream -> all outputs 0, illegal_cnt 0 immediately.
